branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter ENTRIES, default 16: number of direct-mapped entries; power of two, at least 2.
REQ-002 SHALL have parameter ADDR_W, default 32: PC and target width.
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port fetch_valid, input, 1: lookup request this cycle.
REQ-006 SHALL have port fetch_pc, input, ADDR_W: PC to look up.
REQ-007 SHALL have port flush, input, 1: cancels the in-flight lookup.
REQ-008 SHALL have port pht_taken, input, 1: direction prediction from the global-history predictor, aligned with the response cycle.
REQ-009 SHALL have port update_valid, input, 1: resolved-branch writeback strobe.
REQ-010 SHALL have port update_pc, input, ADDR_W: PC of the resolved branch.
REQ-011 SHALL have port update_target, input, ADDR_W: resolved target.
REQ-012 SHALL have port update_taken, input, 1: resolved direction.
REQ-013 SHALL have port pred_valid, output, 1: response valid.
REQ-014 SHALL have port btb_hit, output, 1: the looked-up PC matched a valid entry.
REQ-015 SHALL have port predict_taken, output, 1: final redirect decision.
REQ-016 SHALL have port predict_target, output, ADDR_W: redirect target.

Function
REQ-017 SHALL map index = pc[log2(ENTRIES)+1:2] and tag = pc[ADDR_W-1:log2(ENTRIES)+2]; pc[1:0] SHALL be ignored.
REQ-018 SHALL store valid (1 bit), tag and target per entry.
REQ-019 SHALL answer lookups with 1-cycle latency: a request accepted at edge N drives pred_valid=1 during cycle N+1 only.
REQ-020 SHALL sample index/tag match and target at edge N into the response register; later array writes SHALL NOT alter an issued response.
REQ-021 SHALL set btb_hit = entry valid AND stored tag equals the lookup tag, and hold btb_hit = 0 when pred_valid = 0.
REQ-022 SHALL drive predict_taken = pred_valid AND btb_hit AND pht_taken, combinationally from pht_taken in the response cycle.
REQ-023 SHALL drive predict_target = stored target on a hit, else lookup PC + 4 (modulo 2^ADDR_W), and 0 when pred_valid = 0.
REQ-024 SHALL, when update_valid=1 and update_taken=1 at an edge, write valid=1, tag and target at the update index, overwriting any alias.
REQ-025 SHALL, when update_valid=1 and update_taken=0, leave the array unchanged.
REQ-026 SHALL suppress the response when flush=1: pred_valid=0 in the following cycle regardless of fetch_valid; flush dominates a simultaneous request.
REQ-027 SHALL accept back-to-back lookups, one per cycle, with no stalls.
REQ-028 SHALL, on a lookup and update to the same index at the same edge, read the pre-update contents (unless REQ-034 applies).

Reset
REQ-029 SHALL, while RST=1, clear all valid bits, pred_valid, btb_hit and predict_taken, and drive predict_target = 0, without waiting for a clock edge.
REQ-030 SHALL discard any in-flight lookup when reset is asserted mid-operation; no response SHALL appear after reset deasserts.
REQ-031 SHALL NOT reset tag/target storage; only valid bits are cleared.
REQ-032 SHALL accept a lookup at the first rising edge after RST deasserts.

Configuration
REQ-033 SHALL gate same-cycle write-to-read forwarding with macro BTB_BYPASS_EN.
REQ-034 SHALL, with BTB_BYPASS_EN defined, return hit/target from a taken update at the same edge when index and tag both match the lookup, as if written first.
REQ-035 SHALL, without BTB_BYPASS_EN, behave per REQ-028; all other behaviour is identical in both builds.

Verification
REQ-036 SHALL cover cold miss: after reset, lookup 0x0000_1000 -> next cycle pred_valid=1, btb_hit=0, predict_target=0x0000_1004, predict_taken=0.
REQ-037 SHALL cover training and hit: update 0x0000_1000 taken, target 0x0000_2000, then lookup 0x0000_1000 with pht_taken=1 -> btb_hit=1, predict_taken=1, predict_target=0x0000_2000; with pht_taken=0 -> predict_taken=0, btb_hit=1.
REQ-038 SHALL cover aliasing: train 0x0000_1000, then update 0x0000_1040 taken to 0x0000_3000 -> lookup 0x0000_1000 misses; lookup 0x0000_1040 hits with target 0x0000_3000.
REQ-039 SHALL cover the same-edge collision: lookup and taken update 0x0000_1000 at one edge -> btb_hit=0 without BTB_BYPASS_EN; btb_hit=1, target=update_target with it.
REQ-040 SHALL cover flush and reset: flush with fetch_valid -> pred_valid=0 next cycle; assert RST mid-stream after training -> outputs 0 immediately, then a lookup of the trained PC misses.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a one-cycle registered lookup response.
// Define BTB_BYPASS_EN to forward a same-edge taken update into the lookup result.
module branch_target_buffer #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              flush,
  input  logic              pht_taken,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic [ADDR_W-1:0] update_target,
  input  logic              update_taken,
  output logic              pred_valid,
  output logic              btb_hit,
  output logic              predict_taken,
  output logic [ADDR_W-1:0] predict_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [ADDR_W-1:0]  tgt_mem [ENTRIES];

  logic [IDX_W-1:0]   lk_idx, upd_idx;
  logic [TAG_W-1:0]   lk_tag, upd_tag;
  logic               upd_we;
  logic               lk_hit;
  logic [ADDR_W-1:0]  lk_target;

  logic               rsp_valid, rsp_hit;
  logic [ADDR_W-1:0]  rsp_target;

  // The two byte-offset bits never participate in index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0]};

  assign lk_idx  = fetch_pc[IDX_W+1:2];
  assign lk_tag  = fetch_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = update_pc[IDX_W+1:2];
  assign upd_tag = update_pc[ADDR_W-1:IDX_W+2];
  assign upd_we  = update_valid && update_taken;

  always_comb begin
    lk_hit    = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    lk_target = lk_hit ? tgt_mem[lk_idx] : fetch_pc + ADDR_W'(4);
`ifdef BTB_BYPASS_EN
    if (upd_we && (upd_idx == lk_idx) && (upd_tag == lk_tag)) begin
      lk_hit    = 1'b1;
      lk_target = update_target;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
    end else if (upd_we) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Tag and target storage is intentionally left unreset; valid bits gate its use.
  always_ff @(posedge CLK) begin
    if (upd_we) begin
      tag_mem[upd_idx] <= upd_tag;
      tgt_mem[upd_idx] <= update_target;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_target <= '0;
    end else begin
      rsp_valid  <= fetch_valid && !flush;
      rsp_hit    <= lk_hit;
      rsp_target <= lk_target;
    end
  end

  assign pred_valid     = rsp_valid;
  assign btb_hit        = rsp_valid && rsp_hit;
  assign predict_taken  = rsp_valid && rsp_hit && pht_taken;
  assign predict_target = rsp_valid ? rsp_target : '0;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus random traffic
// compared every cycle against a word-address keyed behavioural model.
module tb_branch_target_buffer;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned AW      = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          fetch_valid = 1'b0;
  logic [AW-1:0] fetch_pc = '0;
  logic          flush = 1'b0;
  logic          pht_taken = 1'b0;
  logic          update_valid = 1'b0;
  logic [AW-1:0] update_pc = '0;
  logic [AW-1:0] update_target = '0;
  logic          update_taken = 1'b0;
  logic          pred_valid, btb_hit, predict_taken;
  logic [AW-1:0] predict_target;

  always #5 CLK = ~CLK;

  branch_target_buffer #(.ENTRIES(ENTRIES), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .flush(flush),
    .pht_taken(pht_taken),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_target(update_target), .update_taken(update_taken),
    .pred_valid(pred_valid), .btb_hit(btb_hit),
    .predict_taken(predict_taken), .predict_target(predict_target)
  );

  // Model: each slot remembers the full word address (pc >> 2) of the branch it holds.
  bit          m_valid [ENTRIES];
  logic [29:0] m_word  [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  bit          e_valid, e_hit;
  logic [31:0] e_tgt;

  int n_pass  = 0;
  int n_total = 0;

  function automatic int unsigned slot_of(logic [31:0] pc);
    return (pc >> 2) % ENTRIES;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
  endtask

  // Apply inputs for one cycle and compare the response visible in this cycle.
  task automatic drive(input bit fv, input logic [31:0] fpc, input bit fl,
                       input bit uv, input logic [31:0] upc, input logic [31:0] utgt,
                       input bit ut, input bit pht);
    fetch_valid = fv; fetch_pc = fpc; flush = fl;
    update_valid = uv; update_pc = upc; update_target = utgt; update_taken = ut;
    pht_taken = pht;
    #1;
    chk("pred_valid",     {31'd0, pred_valid},    {31'd0, e_valid});
    chk("btb_hit",        {31'd0, btb_hit},       {31'd0, e_valid && e_hit});
    chk("predict_taken",  {31'd0, predict_taken}, {31'd0, e_valid && e_hit && pht});
    chk("predict_target", predict_target,         e_valid ? e_tgt : 32'd0);
  endtask

  // Advance the model across the coming edge, then step past it.
  task automatic tick();
    int unsigned s;
    bit          h;
    logic [31:0] t;
    s = slot_of(fetch_pc);
    h = m_valid[s] && (m_word[s] == fetch_pc[31:2]);
    t = h ? m_tgt[s] : fetch_pc + 32'd4;
`ifdef BTB_BYPASS_EN
    if (update_valid && update_taken && update_pc[31:2] == fetch_pc[31:2]) begin
      h = 1'b1;
      t = update_target;
    end
`endif
    if (update_valid && update_taken) begin
      s = slot_of(update_pc);
      m_valid[s] = 1'b1;
      m_word[s]  = update_pc[31:2];
      m_tgt[s]   = update_target;
    end
    e_valid = fetch_valid && !flush;
    e_hit   = h;
    e_tgt   = t;
    @(posedge CLK);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc, input bit pht);
    drive(1'b1, pc, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, pht);
  endtask

  task automatic idle(input bit pht);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, pht);
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt);
    drive(1'b0, 32'd0, 1'b0, 1'b1, pc, tgt, 1'b1, 1'b0);
  endtask

  task automatic outputs_zero(string tag);
    chk({tag, "_pred_valid"},     {31'd0, pred_valid},    32'd0);
    chk({tag, "_btb_hit"},        {31'd0, btb_hit},       32'd0);
    chk({tag, "_predict_taken"},  {31'd0, predict_taken}, 32'd0);
    chk({tag, "_predict_target"}, predict_target,         32'd0);
  endtask

  initial begin
    for (int i = 0; i < int'(ENTRIES); i++) m_valid[i] = 1'b0;
    e_valid = 1'b0; e_hit = 1'b0; e_tgt = '0;

    #1 RST = 1'b1;
    #1 outputs_zero("reset");
    @(posedge CLK); @(posedge CLK); #1 RST = 1'b0;

    // Cold miss
    lookup(32'h0000_1000, 1'b0); tick();
    idle(1'b1);
    chk("cold_valid",  {31'd0, pred_valid},    32'd1);
    chk("cold_hit",    {31'd0, btb_hit},       32'd0);
    chk("cold_taken",  {31'd0, predict_taken}, 32'd0);
    chk("cold_target", predict_target,         32'h0000_1004);
    tick();

    // Training and hit, with both predictor directions
    train(32'h0000_1000, 32'h0000_2000); tick();
    lookup(32'h0000_1000, 1'b0); tick();
    lookup(32'h0000_1000, 1'b1);
    chk("hit_hit",    {31'd0, btb_hit},       32'd1);
    chk("hit_taken",  {31'd0, predict_taken}, 32'd1);
    chk("hit_target", predict_target,         32'h0000_2000);
    tick();
    idle(1'b0);
    chk("hit_nt_hit",   {31'd0, btb_hit},       32'd1);
    chk("hit_nt_taken", {31'd0, predict_taken}, 32'd0);
    tick();

    // Aliasing: 0x1040 shares the slot of 0x1000
    train(32'h0000_1040, 32'h0000_3000); tick();
    lookup(32'h0000_1000, 1'b1); tick();
    lookup(32'h0000_1040, 1'b1);
    chk("alias_old_hit",    {31'd0, btb_hit}, 32'd0);
    chk("alias_old_target", predict_target,   32'h0000_1004);
    tick();
    idle(1'b1);
    chk("alias_new_hit",    {31'd0, btb_hit}, 32'd1);
    chk("alias_new_target", predict_target,   32'h0000_3000);
    tick();

    // Same-edge lookup and taken update
    drive(1'b1, 32'h0000_1000, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b1, 1'b0); tick();
    idle(1'b1);
`ifdef BTB_BYPASS_EN
    chk("collide_hit",    {31'd0, btb_hit}, 32'd1);
    chk("collide_target", predict_target,   32'h0000_2000);
`else
    chk("collide_hit",    {31'd0, btb_hit}, 32'd0);
    chk("collide_target", predict_target,   32'h0000_1004);
`endif
    tick();

    // Flush dominates a simultaneous request
    drive(1'b1, 32'h0000_1000, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1); tick();
    idle(1'b1);
    chk("flush_valid", {31'd0, pred_valid}, 32'd0);
    tick();

    // Reset mid-stream after training
    lookup(32'h0000_1000, 1'b1); tick();
    lookup(32'h0000_1000, 1'b1);
    RST = 1'b1;
    #1 outputs_zero("midrst");
    for (int i = 0; i < int'(ENTRIES); i++) m_valid[i] = 1'b0;
    e_valid = 1'b0;
    @(posedge CLK); #1;
    outputs_zero("midrst_hold");
    RST = 1'b0;
    lookup(32'h0000_1000, 1'b1); tick();
    idle(1'b1);
    chk("postrst_valid",  {31'd0, pred_valid}, 32'd1);
    chk("postrst_hit",    {31'd0, btb_hit},    32'd0);
    chk("postrst_target", predict_target,      32'h0000_1004);
    tick();

    // Random traffic over a small address pool to exercise hits, aliases and collisions
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] fpc, upc, utgt;
      bit fv, fl, uv, ut;
      fpc  = 32'h0000_1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2)
             + $urandom_range(0, 3);
      upc  = 32'h0000_1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2)
             + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) upc = {fpc[31:2], 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 199) == 0) upc = 32'hFFFF_FFFC;
      if ($urandom_range(0, 199) == 0) fpc = 32'hFFFF_FFFD;
      utgt = $urandom;
      fv   = ($urandom_range(0, 9) < 8);
      fl   = ($urandom_range(0, 9) == 0);
      uv   = ($urandom_range(0, 1) == 1);
      ut   = ($urandom_range(0, 3) != 0);
      drive(fv, fpc, fl, uv, upc, utgt, ut, 1'($urandom_range(0, 1)));
      tick();
    end
    idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
